vga_line_drawer: RTL and testbench

//  Bresenham line engine upstream of the VGA adapter's video memory; one pixel per clock.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/line_bresenham_step.sv | 47 ++++
 rtl/vga_line_drawer.sv | 169 ++++++++++++++++
 tb/tb_vga_line_drawer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and default geometry for the VGA line drawing engine.
package vga_pkg;

  localparam int X_W_DEF   = 9;
  localparam int Y_W_DEF   = 8;
  localparam int COL_W_DEF = 6;
  localparam int H_RES_DEF = 320;
  localparam int V_RES_DEF = 240;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int ERR_W = max_w(X_W_DEF, Y_W_DEF) + 2;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    DRAW,
    DONE
  } line_state_t;

  typedef logic signed [ERR_W-1:0] err_t;

endpackage

// File: rtl/line_bresenham_step.sv
// One combinational Bresenham iteration: next err, cx and cy.
// sx_i/sy_i select +1 when high, -1 when low.
module line_bresenham_step
  import vga_pkg::*;
#(
  parameter int X_W = X_W_DEF,
  parameter int Y_W = Y_W_DEF,
  parameter int EW  = max_w(X_W, Y_W) + 2
) (
  input  logic signed [EW-1:0] err_i,
  input  logic signed [EW-1:0] dx_i,
  input  logic signed [EW-1:0] dy_i,
  input  logic                 sx_i,
  input  logic                 sy_i,
  input  logic [X_W-1:0]       cx_i,
  input  logic [Y_W-1:0]       cy_i,
  output logic signed [EW-1:0] err_o,
  output logic [X_W-1:0]       cx_o,
  output logic [Y_W-1:0]       cy_o
);

  logic signed [EW:0]   e2;
  logic signed [EW:0]   dx_w;
  logic signed [EW:0]   dy_w;
  logic                 step_x;
  logic                 step_y;
  logic signed [EW-1:0] add_x;
  logic signed [EW-1:0] add_y;

  assign e2   = {err_i, 1'b0};
  assign dx_w = {dx_i[EW-1], dx_i};
  assign dy_w = {dy_i[EW-1], dy_i};

  assign step_x = (e2 >= dy_w);
  assign step_y = (e2 <= dx_w);

  // Both corrections are taken from the same pre-update err.
  assign add_x = step_x ? dy_i : '0;
  assign add_y = step_y ? dx_i : '0;
  assign err_o = err_i + add_x + add_y;

  assign cx_o = !step_x ? cx_i
              : (sx_i ? cx_i + X_W'(1) : cx_i - X_W'(1));
  assign cy_o = !step_y ? cy_i
              : (sy_i ? cy_i + Y_W'(1) : cy_i - Y_W'(1));

endmodule

// File: rtl/vga_line_drawer.sv
// Bresenham line engine feeding the VGA adapter write port, one pixel/clock.
// Define LINE_CLIP_EN to suppress plot for pixels outside H_RES x V_RES.
module vga_line_drawer
  import vga_pkg::*;
#(
  parameter int X_W   = X_W_DEF,
  parameter int Y_W   = Y_W_DEF,
  parameter int COL_W = COL_W_DEF,
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [X_W-1:0]   x0,
  input  logic [X_W-1:0]   x1,
  input  logic [Y_W-1:0]   y0,
  input  logic [Y_W-1:0]   y1,
  input  logic [COL_W-1:0] colour_in,
  output logic             busy,
  output logic             done,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic [COL_W-1:0] colour,
  output logic             plot
);

  localparam int EW = max_w(X_W, Y_W) + 2;

  typedef logic signed [EW-1:0] serr_t;

  line_state_t      state_q;
  logic [X_W-1:0]   x0_q;
  logic [X_W-1:0]   x1_q;
  logic [Y_W-1:0]   y0_q;
  logic [Y_W-1:0]   y1_q;
  logic [COL_W-1:0] col_q;
  serr_t            dx_q;
  serr_t            dy_q;
  serr_t            err_q;
  logic             sx_q;
  logic             sy_q;
  logic [X_W-1:0]   cx_q;
  logic [Y_W-1:0]   cy_q;
  logic             busy_q;
  logic             done_q;
  logic             plot_q;
  logic [X_W-1:0]   x_q;
  logic [Y_W-1:0]   y_q;
  logic [COL_W-1:0] colour_q;

  logic [X_W-1:0]   adx;
  logic [Y_W-1:0]   ady;
  serr_t            dx_d;
  serr_t            dy_d;
  serr_t            err_d;
  serr_t            err_step;
  logic [X_W-1:0]   cx_step;
  logic [Y_W-1:0]   cy_step;
  logic             last_px;
  logic             in_view;

  assign adx   = (x1_q >= x0_q) ? x1_q - x0_q : x0_q - x1_q;
  assign ady   = (y1_q >= y0_q) ? y1_q - y0_q : y0_q - y1_q;
  assign dx_d  = serr_t'(adx);
  assign dy_d  = -serr_t'(ady);
  assign err_d = dx_d + dy_d;

  line_bresenham_step #(
    .X_W (X_W),
    .Y_W (Y_W),
    .EW  (EW)
  ) u_step (
    .err_i (err_q),
    .dx_i  (dx_q),
    .dy_i  (dy_q),
    .sx_i  (sx_q),
    .sy_i  (sy_q),
    .cx_i  (cx_q),
    .cy_i  (cy_q),
    .err_o (err_step),
    .cx_o  (cx_step),
    .cy_o  (cy_step)
  );

  assign last_px = (cx_q == x1_q) && (cy_q == y1_q);

`ifdef LINE_CLIP_EN
  assign in_view = (32'(cx_q) < H_RES) && (32'(cy_q) < V_RES);
`else
  assign in_view = 1'b1;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      x0_q     <= '0;
      x1_q     <= '0;
      y0_q     <= '0;
      y1_q     <= '0;
      col_q    <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_q     <= 1'b0;
      sy_q     <= 1'b0;
      cx_q     <= '0;
      cy_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else begin
      done_q <= 1'b0;
      plot_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            x0_q    <= x0;
            x1_q    <= x1;
            y0_q    <= y0;
            y1_q    <= y1;
            col_q   <= colour_in;
            busy_q  <= 1'b1;
            state_q <= INIT;
          end
        end
        INIT: begin
          dx_q    <= dx_d;
          dy_q    <= dy_d;
          err_q   <= err_d;
          sx_q    <= (x0_q < x1_q);
          sy_q    <= (y0_q < y1_q);
          cx_q    <= x0_q;
          cy_q    <= y0_q;
          state_q <= DRAW;
        end
        DRAW: begin
          x_q      <= cx_q;
          y_q      <= cy_q;
          colour_q <= col_q;
          plot_q   <= in_view;
          if (last_px) begin
            state_q <= DONE;
          end else begin
            err_q <= err_step;
            cx_q  <= cx_step;
            cy_q  <= cy_step;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign plot   = plot_q;
  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;

endmodule

// File: tb/tb_vga_line_drawer.sv
// Self-checking bench for vga_line_drawer: directed, random and reset cases.
module tb_vga_line_drawer;

  typedef logic [25:0] word_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [8:0] x0, x1;
  logic [7:0] y0, y1;
  logic [5:0] colour_in;
  logic       busy, done, plot;
  logic [8:0] x;
  logic [7:0] y;
  logic [5:0] colour;

  int n_tests = 0;
  int n_fail  = 0;

  int    px[$];
  int    py[$];
  bit    pp[$];
  word_t exp_w[$];
  word_t obs[$];
  int    prev_x, prev_y, prev_c;

  vga_line_drawer dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .x0        (x0),
    .x1        (x1),
    .y0        (y0),
    .y1        (y1),
    .colour_in (colour_in),
    .busy      (busy),
    .done      (done),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot)
  );

  always #5 clock = ~clock;

  function automatic word_t mk(bit b, bit d, bit p, int ax, int ay, int c);
    return {b, d, p, 9'(ax), 8'(ay), 6'(c)};
  endfunction

  function automatic bit visible(int cx, int cy);
`ifdef LINE_CLIP_EN
    return (cx < 320) && (cy < 240);
`else
    return 1'b1;
`endif
  endfunction

  // Reference walk of the line using plain integer arithmetic.
  function automatic void ref_line(int ax0, int ay0, int ax1, int ay1);
    int dx, dy, sx, sy, err, e2, cx, cy;
    px.delete(); py.delete(); pp.delete();
    dx  = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    dy  = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
    sx  = (ax0 < ax1) ? 1 : -1;
    sy  = (ay0 < ay1) ? 1 : -1;
    err = dx + dy;
    cx  = ax0;
    cy  = ay0;
    while (px.size() < 2000) begin
      px.push_back(cx);
      py.push_back(cy);
      pp.push_back(visible(cx, cy));
      if (cx == ax1 && cy == ay1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; cx += sx; end
      if (e2 <= dx) begin err += dx; cy += sy; end
    end
  endfunction

  function automatic void build_exp(int col, bit tail);
    int n;
    n = px.size();
    exp_w.delete();
    exp_w.push_back(mk(1, 0, 0, prev_x, prev_y, prev_c));
    exp_w.push_back(mk(1, 0, 0, prev_x, prev_y, prev_c));
    for (int i = 0; i < n; i++)
      exp_w.push_back(mk(1, 0, pp[i], px[i], py[i], col));
    exp_w.push_back(mk(0, 1, 0, px[n-1], py[n-1], col));
    if (tail)
      exp_w.push_back(mk(0, 0, 0, px[n-1], py[n-1], col));
    prev_x = px[n-1];
    prev_y = py[n-1];
    prev_c = col;
  endfunction

  // Called at a negedge; samples one word per following negedge.
  task automatic drive_line(int ax0, int ay0, int ax1, int ay1,
                            int col, int ncyc, bit mid);
    obs.delete();
    x0 = 9'(ax0); y0 = 8'(ay0);
    x1 = 9'(ax1); y1 = 8'(ay1);
    colour_in = 6'(col);
    start = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clock);
      obs.push_back({busy, done, plot, x, y, colour});
      if (i == 0) start = 1'b0;
      if (mid && i == 3) begin
        x0 = 9'($urandom_range(0, 319));
        x1 = 9'($urandom_range(0, 319));
        y0 = 8'($urandom_range(0, 239));
        y1 = 8'($urandom_range(0, 239));
        colour_in = 6'($urandom);
        start = 1'b1;
      end
      if (mid && i == 4) start = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0; colour_in = '0;
    prev_x = 0; prev_y = 0; prev_c = 0;
    repeat (3) @(negedge clock);
    n_tests++;
    if ({busy, done, plot, x, y, colour} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want 0",
               {busy, done, plot, x, y, colour});
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_directed;
    int c;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin
          px = '{0, 1, 2, 3}; py = '{0, 0, 0, 0}; pp = '{1, 1, 1, 1};
          c = 6'h30;
        end
        1: begin
          px = '{5}; py = '{5}; pp = '{1};
          c = 6'h0f;
        end
        2: begin
          px = '{10, 9, 8, 7}; py = '{10, 9, 8, 7}; pp = '{1, 1, 1, 1};
          c = 6'h15;
        end
        default: begin
          px = '{0, 0, 1, 1}; py = '{0, 1, 2, 3}; pp = '{1, 1, 1, 1};
          c = 6'h2a;
        end
      endcase
      build_exp(c, 1'b1);
      drive_line(px[0], py[0], px[px.size()-1], py[py.size()-1],
                 c, exp_w.size(), 1'b0);
      for (int i = 0; i < exp_w.size(); i++) begin
        n_tests++;
        if (obs[i] !== exp_w[i]) begin
          n_fail++;
          $display("FAIL directed%0d cyc %0d: got %h want %h",
                   k + 1, i, obs[i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_random;
    int ax0, ay0, ax1, ay1, c;
    for (int k = 0; k < 30; k++) begin
      ax0 = $urandom_range(0, 319);
      ax1 = (k % 3 == 0) ? ax0 : $urandom_range(0, 319);
      ay0 = $urandom_range(0, 239);
      ay1 = (k % 5 == 1) ? ay0 : $urandom_range(0, 239);
      c   = $urandom_range(0, 63);
      ref_line(ax0, ay0, ax1, ay1);
      build_exp(c, 1'b1);
      drive_line(ax0, ay0, ax1, ay1, c, exp_w.size(), 1'b0);
      for (int i = 0; i < exp_w.size(); i++) begin
        n_tests++;
        if (obs[i] !== exp_w[i]) begin
          n_fail++;
          $display("FAIL random%0d (%0d,%0d)->(%0d,%0d) cyc %0d: got %h want %h",
                   k, ax0, ay0, ax1, ay1, i, obs[i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_mid_start;
    ref_line(3, 40, 20, 31);
    build_exp(6'h21, 1'b1);
    drive_line(3, 40, 20, 31, 6'h21, exp_w.size(), 1'b1);
    for (int i = 0; i < exp_w.size(); i++) begin
      n_tests++;
      if (obs[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL mid_start cyc %0d: got %h want %h",
                 i, obs[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    ref_line(50, 60, 44, 70);
    build_exp(6'h07, 1'b0);
    drive_line(50, 60, 44, 70, 6'h07, exp_w.size(), 1'b0);
    for (int i = 0; i < exp_w.size(); i++) begin
      n_tests++;
      if (obs[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL b2b_first cyc %0d: got %h want %h",
                 i, obs[i], exp_w[i]);
      end
    end
    ref_line(200, 100, 205, 98);
    build_exp(6'h38, 1'b1);
    drive_line(200, 100, 205, 98, 6'h38, exp_w.size(), 1'b0);
    for (int i = 0; i < exp_w.size(); i++) begin
      n_tests++;
      if (obs[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL b2b_second cyc %0d: got %h want %h",
                 i, obs[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_reset_mid_line;
    drive_line(0, 0, 100, 50, 6'h3c, 6, 1'b0);
    reset = 1'b1;
    #1;
    n_tests++;
    if ({busy, done, plot} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_line: got busy/done/plot %b want 000",
               {busy, done, plot});
    end
    @(negedge clock);
    reset = 1'b0;
    prev_x = 0; prev_y = 0; prev_c = 0;
    n_tests++;
    if ({busy, done, plot, x, y, colour} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %h want 0",
               {busy, done, plot, x, y, colour});
    end
    ref_line(2, 3, 6, 1);
    build_exp(6'h11, 1'b1);
    drive_line(2, 3, 6, 1, 6'h11, exp_w.size(), 1'b0);
    for (int i = 0; i < exp_w.size(); i++) begin
      n_tests++;
      if (obs[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL after_reset cyc %0d: got %h want %h",
                 i, obs[i], exp_w[i]);
      end
    end
  endtask

`ifdef LINE_CLIP_EN
  task automatic test_clip;
    px = '{318, 319, 320, 321}; py = '{0, 0, 0, 0}; pp = '{1, 1, 0, 0};
    build_exp(6'h3f, 1'b1);
    drive_line(318, 0, 321, 0, 6'h3f, exp_w.size(), 1'b0);
    for (int i = 0; i < exp_w.size(); i++) begin
      n_tests++;
      if (obs[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL clip cyc %0d: got %h want %h",
                 i, obs[i], exp_w[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_mid_start();
    test_back_to_back();
    test_reset_mid_line();
`ifdef LINE_CLIP_EN
    test_clip();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
